// File: rtl/mm_stream_tx.sv
// Matrix-stream transmitter: holds operands A and B, streams them row-major into MM, then tracks MM busy.
// Optional busy-rise watchdog (adds port err and parameter TIMEOUT) enabled by defining MM_TX_TIMEOUT_EN.
module mm_stream_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_DIM    = 4,
  parameter int unsigned GAP_CYCLES = 2
`ifdef MM_TX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT  = 256
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [1:0]        wr_row,
  input  logic [1:0]        wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        a_rows_m1,
  input  logic [1:0]        a_cols_m1,
  input  logic [1:0]        b_rows_m1,
  input  logic [1:0]        b_cols_m1,
  input  logic              start,
  input  logic              busy,
  output logic [DATA_W-1:0] in_data,
  output logic              row_end,
  output logic              col_end,
  output logic              ready,
  output logic              done
`ifdef MM_TX_TIMEOUT_EN
  , output logic            err
`endif
);

  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
`ifdef MM_TX_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_A, S_SEND_B, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          r_q, r_d, c_q, c_d;
  logic [1:0]          a_rows_q, a_rows_d, a_cols_q, a_cols_d;
  logic [1:0]          b_rows_q, b_rows_d, b_cols_q, b_cols_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DATA_W-1:0]   in_data_d;
  logic                row_end_d, col_end_d, ready_d, done_d;
`ifdef MM_TX_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_d;
`endif

  // Element selected for the output register on the next edge
  logic                emit, emit_sel;
  logic [1:0]          emit_r, emit_c, emit_rows, emit_cols;
  logic [1:0]          cur_rows, cur_cols, nxt_r, nxt_c;
  logic                last_col, last_elem;

  logic [DATA_W-1:0]   mem [2][MAX_DIM][MAX_DIM];

  // Operand store; host writes only land while idle
  always_ff @(posedge clk) begin
    if (wr_en && ready) mem[wr_sel][wr_row][wr_col] <= wr_data;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      c_q      <= '0;
      a_rows_q <= '0;
      a_cols_q <= '0;
      b_rows_q <= '0;
      b_cols_q <= '0;
      gap_q    <= '0;
      in_data  <= '0;
      row_end  <= 1'b0;
      col_end  <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
`ifdef MM_TX_TIMEOUT_EN
      tmo_q    <= '0;
      err      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      a_rows_q <= a_rows_d;
      a_cols_q <= a_cols_d;
      b_rows_q <= b_rows_d;
      b_cols_q <= b_cols_d;
      gap_q    <= gap_d;
      in_data  <= in_data_d;
      row_end  <= row_end_d;
      col_end  <= col_end_d;
      ready    <= ready_d;
      done     <= done_d;
`ifdef MM_TX_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err      <= err_d;
`endif
    end
  end

  // Next-state and next-output logic; (r_q, c_q) is the element currently on in_data
  always_comb begin
    state_d   = state_q;
    a_rows_d  = a_rows_q;
    a_cols_d  = a_cols_q;
    b_rows_d  = b_rows_q;
    b_cols_d  = b_cols_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    emit      = 1'b0;
    emit_sel  = 1'b0;
    emit_r    = '0;
    emit_c    = '0;
    emit_rows = '0;
    emit_cols = '0;
`ifdef MM_TX_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = 1'b0;
`endif

    cur_rows  = (state_q == S_SEND_B) ? b_rows_q : a_rows_q;
    cur_cols  = (state_q == S_SEND_B) ? b_cols_q : a_cols_q;
    last_col  = (c_q == cur_cols);
    last_elem = last_col && (r_q == cur_rows);
    nxt_r     = last_col ? (r_q + 2'd1) : r_q;
    nxt_c     = last_col ? 2'd0 : (c_q + 2'd1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_rows_d  = a_rows_m1;
          a_cols_d  = a_cols_m1;
          b_rows_d  = b_rows_m1;
          b_cols_d  = b_cols_m1;
          state_d   = S_SEND_A;
          emit      = 1'b1;
          emit_rows = a_rows_m1;
          emit_cols = a_cols_m1;
        end
      end
      S_SEND_A: begin
        emit = 1'b1;
        if (last_elem) begin
          state_d   = S_SEND_B;
          emit_sel  = 1'b1;
          emit_rows = b_rows_q;
          emit_cols = b_cols_q;
        end else begin
          emit_r    = nxt_r;
          emit_c    = nxt_c;
          emit_rows = a_rows_q;
          emit_cols = a_cols_q;
        end
      end
      S_SEND_B: begin
        if (last_elem) begin
          state_d = S_WAIT_BUSY;
`ifdef MM_TX_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          emit      = 1'b1;
          emit_sel  = 1'b1;
          emit_r    = nxt_r;
          emit_c    = nxt_c;
          emit_rows = b_rows_q;
          emit_cols = b_cols_q;
        end
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
        end else begin
`ifdef MM_TX_TIMEOUT_EN
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmo_d   = tmo_q + TMO_W'(1);
          end
`endif
        end
      end
      S_WAIT_DONE: begin
        // Entered only after busy was seen high, so low here is the falling edge
        if (!busy) begin
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if ((32'(gap_q) + 32'd1) >= GAP_CYCLES) state_d = S_IDLE;
        else gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    r_d       = emit_r;
    c_d       = emit_c;
    in_data_d = emit ? mem[emit_sel][emit_r][emit_c] : '0;
    col_end_d = emit && (emit_c == emit_cols);
    row_end_d = col_end_d && (emit_r == emit_rows);
    ready_d   = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_mm_stream_tx.sv
// Self-checking bench for mm_stream_tx: directed jobs plus randomized jobs against a queue-based stream model.
module tb_mm_stream_tx;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0, wr_sel = 1'b0;
  logic [1:0] wr_row = '0, wr_col = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] a_rows_m1 = '0, a_cols_m1 = '0, b_rows_m1 = '0, b_cols_m1 = '0;
  logic       start = 1'b0, busy = 1'b0;
  logic [7:0] in_data;
  logic       row_end, col_end, ready, done;
`ifdef MM_TX_TIMEOUT_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  mm_stream_tx #(.DATA_W(8), .MAX_DIM(4), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .a_rows_m1(a_rows_m1), .a_cols_m1(a_cols_m1), .b_rows_m1(b_rows_m1), .b_cols_m1(b_cols_m1),
    .start(start), .busy(busy),
    .in_data(in_data), .row_end(row_end), .col_end(col_end), .ready(ready), .done(done)
`ifdef MM_TX_TIMEOUT_EN
    , .err(err)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];

  typedef struct packed {
    logic [7:0] d;
    logic       ce;
    logic       re;
  } elem_t;
  elem_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge while the DUT is idle
  task automatic write_elem(input logic sel, input int r, input int c, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) mb[r][c] = d;
    else     ma[r][c] = d;
  endtask

  // Expected stream: A then B row-major, col_end on row tails, row_end on the matrix tail
  task automatic build_expected(input int ar, input int ac, input int br, input int bc);
    elem_t e;
    exp_q.delete();
    for (int r = 0; r <= ar; r++)
      for (int c = 0; c <= ac; c++) begin
        e.d = ma[r][c]; e.ce = (c == ac); e.re = (c == ac) && (r == ar);
        exp_q.push_back(e);
      end
    for (int r = 0; r <= br; r++)
      for (int c = 0; c <= bc; c++) begin
        e.d = mb[r][c]; e.ce = (c == bc); e.re = (c == bc) && (r == br);
        exp_q.push_back(e);
      end
  endtask

  task automatic check_stream_elem(input int k);
    check("in_data", 32'(in_data), 32'(exp_q[k].d));
    check("col_end", 32'(col_end), 32'(exp_q[k].ce));
    check("row_end", 32'(row_end), 32'(exp_q[k].re));
    check("ready_stream", 32'(ready), 32'd0);
  endtask

  // Full job; poke pulses start during the job and writes A[0][0] at the first B element
  task automatic run_job(input int ar, input int ac, input int br, input int bc,
                         input int busy_delay, input int busy_len,
                         input bit early_busy, input bit poke);
    int na;
    build_expected(ar, ac, br, bc);
    na = (ar + 1) * (ac + 1);
    check("ready_before_start", 32'(ready), 32'd1);
    a_rows_m1 = 2'(ar); a_cols_m1 = 2'(ac); b_rows_m1 = 2'(br); b_cols_m1 = 2'(bc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check_stream_elem(k);
      check("done_stream", 32'(done), 32'd0);
      if (poke) begin
        start = 1'b1;
        if (k == na) begin
          wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = ~ma[0][0];
        end
      end
      if (early_busy && k == exp_q.size() / 2) busy = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
    end
    check("idle_in_data", 32'(in_data), 32'd0);
    check("idle_markers", 32'({row_end, col_end}), 32'd0);
    for (int i = 0; i < busy_delay; i++) begin
      check("ready_wait", 32'(ready), 32'd0);
      check("done_wait", 32'(done), 32'd0);
      start = poke;
      @(negedge clk);
      start = 1'b0;
    end
    busy = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      @(negedge clk);
      check("done_busy", 32'(done), 32'd0);
      check("ready_busy", 32'(ready), 32'd0);
    end
    busy = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("ready_at_done", 32'(ready), 32'd0);
    for (int i = 1; i < GAP; i++) begin
      @(negedge clk);
      check("done_gap", 32'(done), 32'd0);
      check("ready_gap", 32'(ready), 32'd0);
    end
    @(negedge clk);
    check("ready_after_gap", 32'(ready), 32'd1);
    check("done_after_gap", 32'(done), 32'd0);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    check("rst_in_data", 32'(in_data), 32'd0);
    check("rst_markers", 32'({row_end, col_end}), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 2x2 x 2x2, with start pokes and an A[0][0] write during SEND_B
    write_elem(1'b0, 0, 0, 8'd1); write_elem(1'b0, 0, 1, 8'd2);
    write_elem(1'b0, 1, 0, 8'd3); write_elem(1'b0, 1, 1, 8'd4);
    write_elem(1'b1, 0, 0, 8'd5); write_elem(1'b1, 0, 1, 8'd6);
    write_elem(1'b1, 1, 0, 8'd7); write_elem(1'b1, 1, 1, 8'd8);
    run_job(1, 1, 1, 1, 3, 10, 1'b0, 1'b1);
    // The ignored write must leave A[0][0]=1 in the next job
    run_job(1, 1, 1, 1, 0, 1, 1'b0, 1'b0);

    // 1x3 x 3x1
    write_elem(1'b0, 0, 0, 8'd1); write_elem(1'b0, 0, 1, 8'd2); write_elem(1'b0, 0, 2, 8'd3);
    write_elem(1'b1, 0, 0, 8'd4); write_elem(1'b1, 1, 0, 8'd5); write_elem(1'b1, 2, 0, 8'd6);
    run_job(0, 2, 2, 0, 1, 2, 1'b0, 1'b0);

    // Busy raised before the stream ends
    run_job(0, 2, 2, 0, 2, 3, 1'b1, 1'b0);

    // 1x1 x 1x1 corner
    run_job(0, 0, 0, 0, 0, 1, 1'b0, 1'b1);

    // Reset in the middle of a 4x4 A stream
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        write_elem(1'b0, r, c, 8'($urandom));
        write_elem(1'b1, r, c, 8'($urandom));
      end
    build_expected(3, 3, 3, 3);
    a_rows_m1 = 2'd3; a_cols_m1 = 2'd3; b_rows_m1 = 2'd3; b_cols_m1 = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_stream_elem(k);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("abort_in_data", 32'(in_data), 32'd0);
    check("abort_markers", 32'({row_end, col_end}), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_job(3, 3, 3, 3, 1, 2, 1'b0, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      for (int w = 0; w < 6; w++)
        write_elem(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 8'($urandom));
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), int'($urandom_range(1, 5)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
